// File: rtl/vx_fpu_pkg.sv
// Shared FPU CSR types: fflags layout, CSR addresses, CSR op encoding,
// CSR state machine states and the read-modify-write helper.
package vx_fpu_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } csr_state_e;

    // New field value for a CSR op; callers zero-extend narrow fields and slice back.
    function automatic logic [7:0] csr_apply(input logic [1:0] op,
                                             input logic [7:0] old_val,
                                             input logic [7:0] operand);
        logic [7:0] res;
        case (csr_op_e'(op))
            CSR_OP_WRITE: res = operand;
            CSR_OP_SET:   res = old_val | operand;
            CSR_OP_CLEAR: res = old_val & ~operand;
            default:      res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/vx_fpu_pend_ctr.sv
// Per-warp in-flight FPU op counters; saturating inc, underflow-protected dec.
// Only built when FPU_CSR_DRAIN_EN is defined (the only configuration that uses it).
`ifdef FPU_CSR_DRAIN_EN
module vx_fpu_pend_ctr #(
    parameter int NUM_WARPS = 4,
    parameter int PEND_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WARPS-1:0] inc,
    input  logic [NUM_WARPS-1:0] dec,
    output logic [NUM_WARPS-1:0] zero,
    output logic [NUM_WARPS-1:0] full
);

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        logic [PEND_W-1:0] cnt_q, cnt_d;
        logic              inc_ok, dec_ok;

        assign zero[w] = (cnt_q == '0);
        assign full[w] = (cnt_q == '1);
        assign inc_ok  = inc[w] && !full[w];
        assign dec_ok  = dec[w] && !zero[w];

        // Simultaneous inc and dec cancel out.
        always_comb begin
            cnt_d = cnt_q;
            case ({inc_ok, dec_ok})
                2'b10:   cnt_d = cnt_q + PEND_W'(1);
                2'b01:   cnt_d = cnt_q - PEND_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        // Counter register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        // A retire with nothing in flight is a pipeline bug upstream.
        a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
                                         !(dec[w] && zero[w]));
    end

endmodule
`endif

// File: rtl/vx_fpu_csr_store.sv
// Per-warp fcsr (fflags + frm) storage with a CSR access port.
// Optional macro FPU_CSR_DRAIN_EN: CSR accesses wait until the warp has
// no FPU ops in flight. Without it every access completes in one cycle.
module vx_fpu_csr_store
    import vx_fpu_pkg::*;
#(
    parameter int  NUM_WARPS = 4,
    parameter int  PEND_W    = 4,
    localparam int NW_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [NW_W-1:0] issue_wid,
    output logic            issue_ready,
    input  logic            retire_valid,
    input  logic [NW_W-1:0] retire_wid,
    input  logic            write_enable,
    input  logic [NW_W-1:0] write_wid,
    input  logic [4:0]      write_fflags,
    input  logic [NW_W-1:0] read_wid,
    output logic [2:0]      read_frm,
    input  logic            csr_req_valid,
    output logic            csr_req_ready,
    input  logic [NW_W-1:0] csr_req_wid,
    input  logic [11:0]     csr_req_addr,
    input  logic [1:0]      csr_req_op,
    input  logic [31:0]     csr_req_data,
    output logic            csr_rsp_valid,
    output logic [31:0]     csr_rsp_data
);

    fflags_t [NUM_WARPS-1:0] fflags_q, fflags_d;
    logic [NUM_WARPS-1:0][2:0] frm_q, frm_d;

    csr_state_e      state_q, state_d;
    logic [NW_W-1:0] req_wid_q;
    logic [11:0]     req_addr_q;
    logic [1:0]      req_op_q;
    logic [7:0]      req_data_q;
    logic            rsp_valid_q;
    logic [7:0]      rsp_data_q, rsp_data_d;

    logic            acc_zero, wait_zero, go_resp;
    logic [NW_W-1:0] cur_wid;
    logic [11:0]     cur_addr;
    logic [1:0]      cur_op;
    logic [7:0]      cur_data, old_fcsr, csr_new;
    logic            unused_req_hi;

    assign unused_req_hi = ^csr_req_data[31:8];

`ifdef FPU_CSR_DRAIN_EN
    logic [NUM_WARPS-1:0] pend_inc, pend_dec, pend_zero, pend_full;

    assign issue_ready = !pend_full[issue_wid];
    assign acc_zero    = pend_zero[csr_req_wid];
    assign wait_zero   = pend_zero[req_wid_q];

    // One-hot inc/dec strobes for the counter array.
    always_comb begin
        pend_inc = '0;
        pend_dec = '0;
        pend_inc[issue_wid]  = issue_valid && issue_ready;
        pend_dec[retire_wid] = retire_valid;
    end

    vx_fpu_pend_ctr #(.NUM_WARPS(NUM_WARPS), .PEND_W(PEND_W)) u_pend_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (pend_inc),
        .dec   (pend_dec),
        .zero  (pend_zero),
        .full  (pend_full)
    );
`else
    logic unused_drain;
    assign unused_drain = ^{issue_valid, issue_wid, retire_valid, retire_wid};
    assign issue_ready  = 1'b1;
    assign acc_zero     = 1'b1;
    assign wait_zero    = 1'b1;
`endif

    assign csr_req_ready = (state_q == ST_IDLE);
    assign csr_rsp_valid = rsp_valid_q;
    assign csr_rsp_data  = {24'b0, rsp_data_q};
    assign read_frm      = frm_q[read_wid];

    // In IDLE the update may happen on the accept edge, so use live request fields.
    assign cur_wid  = (state_q == ST_IDLE) ? csr_req_wid       : req_wid_q;
    assign cur_addr = (state_q == ST_IDLE) ? csr_req_addr      : req_addr_q;
    assign cur_op   = (state_q == ST_IDLE) ? csr_req_op        : req_op_q;
    assign cur_data = (state_q == ST_IDLE) ? csr_req_data[7:0] : req_data_q;

    // Next-state: go to RESP once the requesting warp has drained.
    always_comb begin
        state_d = state_q;
        go_resp = 1'b0;
        case (state_q)
            ST_IDLE: if (csr_req_valid) begin
                state_d = acc_zero ? ST_RESP : ST_WAIT;
                go_resp = acc_zero;
            end
            ST_WAIT: if (wait_zero) begin
                state_d = ST_RESP;
                go_resp = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CSR read-modify-write on RESP entry, then async fflags accumulate on top.
    always_comb begin
        fflags_d   = fflags_q;
        frm_d      = frm_q;
        rsp_data_d = rsp_data_q;
        old_fcsr   = {frm_q[cur_wid], fflags_q[cur_wid]};
        csr_new    = '0;
        if (go_resp) begin
            case (cur_addr)
                CSR_FFLAGS: begin
                    rsp_data_d = {3'b0, old_fcsr[4:0]};
                    csr_new    = csr_apply(cur_op, {3'b0, old_fcsr[4:0]}, {3'b0, cur_data[4:0]});
                    fflags_d[cur_wid] = csr_new[4:0];
                end
                CSR_FRM: begin
                    rsp_data_d = {5'b0, old_fcsr[7:5]};
                    csr_new    = csr_apply(cur_op, {5'b0, old_fcsr[7:5]}, {5'b0, cur_data[2:0]});
                    frm_d[cur_wid] = csr_new[2:0];
                end
                CSR_FCSR: begin
                    rsp_data_d = old_fcsr;
                    csr_new    = csr_apply(cur_op, old_fcsr, cur_data);
                    frm_d[cur_wid]    = csr_new[7:5];
                    fflags_d[cur_wid] = csr_new[4:0];
                end
                default: rsp_data_d = '0;
            endcase
        end
        if (write_enable)
            fflags_d[write_wid] = fflags_d[write_wid] | write_fflags;
    end

    // Architectural fcsr state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fflags_q <= '0;
            frm_q    <= '0;
        end else begin
            fflags_q <= fflags_d;
            frm_q    <= frm_d;
        end
    end

    // CSR FSM, request capture and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            req_wid_q   <= '0;
            req_addr_q  <= '0;
            req_op_q    <= '0;
            req_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_d == ST_RESP);
            rsp_data_q  <= rsp_data_d;
            if (state_q == ST_IDLE && csr_req_valid) begin
                req_wid_q  <= csr_req_wid;
                req_addr_q <= csr_req_addr;
                req_op_q   <= csr_req_op;
                req_data_q <= csr_req_data[7:0];
            end
        end
    end

endmodule

// File: tb/tb_vx_fpu_csr_store.sv
// Directed self-checking bench for vx_fpu_csr_store (NUM_WARPS=4, PEND_W=2).
// Drain-specific sequences are selected by FPU_CSR_DRAIN_EN.
module tb_vx_fpu_csr_store;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_ready;
    logic [1:0]  issue_wid;
    logic        retire_valid;
    logic [1:0]  retire_wid;
    logic        write_enable;
    logic [1:0]  write_wid;
    logic [4:0]  write_fflags;
    logic [1:0]  read_wid;
    logic [2:0]  read_frm;
    logic        csr_req_valid, csr_req_ready;
    logic [1:0]  csr_req_wid;
    logic [11:0] csr_req_addr;
    logic [1:0]  csr_req_op;
    logic [31:0] csr_req_data;
    logic        csr_rsp_valid;
    logic [31:0] csr_rsp_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] rd;
    int          lat;

    always #5 clk = ~clk;

    vx_fpu_csr_store #(.NUM_WARPS(4), .PEND_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_wid     (issue_wid),
        .issue_ready   (issue_ready),
        .retire_valid  (retire_valid),
        .retire_wid    (retire_wid),
        .write_enable  (write_enable),
        .write_wid     (write_wid),
        .write_fflags  (write_fflags),
        .read_wid      (read_wid),
        .read_frm      (read_frm),
        .csr_req_valid (csr_req_valid),
        .csr_req_ready (csr_req_ready),
        .csr_req_wid   (csr_req_wid),
        .csr_req_addr  (csr_req_addr),
        .csr_req_op    (csr_req_op),
        .csr_req_data  (csr_req_data),
        .csr_rsp_valid (csr_rsp_valid),
        .csr_rsp_data  (csr_rsp_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CSR access from IDLE with an optional same-cycle fflags write; returns data and latency.
    task automatic csr_acc(input logic [1:0] wid, input logic [11:0] addr, input logic [1:0] op,
                           input logic [31:0] data, input logic we, input logic [1:0] wwid,
                           input logic [4:0] wfl, output logic [31:0] rdata, output int latency);
        check("req_ready", {31'b0, csr_req_ready}, 32'd1);
        csr_req_valid = 1'b1;  csr_req_wid = wid;  csr_req_addr = addr;
        csr_req_op = op;       csr_req_data = data;
        write_enable = we;     write_wid = wwid;   write_fflags = wfl;
        tick();
        csr_req_valid = 1'b0;  write_enable = 1'b0;
        latency = 1;
        while (!csr_rsp_valid && latency < 20) begin
            tick();
            latency++;
        end
        check("rsp_valid", {31'b0, csr_rsp_valid}, 32'd1);
        rdata = csr_rsp_data;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        issue_valid = 0; issue_wid = 0; retire_valid = 0; retire_wid = 0;
        write_enable = 0; write_wid = 0; write_fflags = 0; read_wid = 0;
        csr_req_valid = 0; csr_req_wid = 0; csr_req_addr = 0; csr_req_op = 0; csr_req_data = 0;
        tick(); tick();
        check("rst_rsp_valid", {31'b0, csr_rsp_valid}, 32'd0);
        check("rst_rsp_data", csr_rsp_data, 32'd0);
        check("rst_req_ready", {31'b0, csr_req_ready}, 32'd1);
        check("rst_issue_ready", {31'b0, issue_ready}, 32'd1);
        check("rst_read_frm", {29'b0, read_frm}, 32'd0);
        reset = 1'b1;
        tick();

        // Read fcsr of warp 0 right after reset.
        csr_acc(2'd0, 12'h003, 2'd0, 32'h0, 1'b0, 2'd0, 5'h0, rd, lat);
        check("fcsr0_rd", rd, 32'h0);
        check("fcsr0_lat", lat, 1);
        check("rsp_drop", {31'b0, csr_rsp_valid}, 32'd0);

        // Write frm=2 on warp 1; warp 0 untouched.
        csr_acc(2'd1, 12'h002, 2'd1, 32'h2, 1'b0, 2'd0, 5'h0, rd, lat);
        check("frm1_wr_old", rd, 32'h0);
        read_wid = 2'd1; #1;
        check("frm1_rd", {29'b0, read_frm}, 32'd2);
        read_wid = 2'd0; #1;
        check("frm0_rd", {29'b0, read_frm}, 32'd0);

        // Registered frm only: during the accept cycle the old value is still visible.
        read_wid = 2'd1;
        csr_req_valid = 1'b1; csr_req_wid = 2'd1; csr_req_addr = 12'h002;
        csr_req_op = 2'd2; csr_req_data = 32'h5; #1;
        check("frm_no_bypass", {29'b0, read_frm}, 32'd2);
        tick();
        csr_req_valid = 1'b0;
        check("frm_set_old", csr_rsp_data, 32'h2);
        check("frm_set_new", {29'b0, read_frm}, 32'd7);
        tick();

        // Clear through fcsr: old fcsr {7,0}=0xE0, frm bits cleared.
        csr_acc(2'd1, 12'h003, 2'd3, 32'hE0, 1'b0, 2'd0, 5'h0, rd, lat);
        check("fcsr1_clr_old", rd, 32'hE0);
        check("frm1_clr", {29'b0, read_frm}, 32'd0);

        // Unknown address: reads 0 and changes nothing.
        csr_acc(2'd1, 12'h004, 2'd1, 32'hFF, 1'b0, 2'd0, 5'h0, rd, lat);
        check("bad_addr_rd", rd, 32'h0);
        csr_acc(2'd1, 12'h003, 2'd0, 32'h0, 1'b0, 2'd0, 5'h0, rd, lat);
        check("bad_addr_nochg", rd, 32'h0);

        // fcsr write 0xFF with same-cycle fflags 0x10 on warp 0.
        csr_acc(2'd0, 12'h003, 2'd1, 32'hFF, 1'b1, 2'd0, 5'h10, rd, lat);
        check("fcsr0_wr_old", rd, 32'h0);
        csr_acc(2'd0, 12'h003, 2'd0, 32'h0, 1'b0, 2'd0, 5'h0, rd, lat);
        check("fcsr0_ff", rd, 32'hFF);
        csr_acc(2'd0, 12'h001, 2'd0, 32'h0, 1'b0, 2'd0, 5'h0, rd, lat);
        check("fflags0_1f", rd, 32'h1F);
        // CSR result first, then flags ORed: write 0 + flag 0x04 leaves 0x04.
        csr_acc(2'd0, 12'h003, 2'd1, 32'h00, 1'b1, 2'd0, 5'h04, rd, lat);
        check("fcsr0_wr2_old", rd, 32'hFF);
        csr_acc(2'd0, 12'h003, 2'd0, 32'h0, 1'b0, 2'd0, 5'h0, rd, lat);
        check("fcsr0_order", rd, 32'h04);

        // Standalone fflags accumulate on warp 1.
        write_enable = 1'b1; write_wid = 2'd1; write_fflags = 5'h08;
        tick();
        write_fflags = 5'h01;
        tick();
        write_enable = 1'b0;
        csr_acc(2'd1, 12'h001, 2'd0, 32'h0, 1'b0, 2'd0, 5'h0, rd, lat);
        check("fflags1_acc", rd, 32'h09);

`ifdef FPU_CSR_DRAIN_EN
        // Two ops in flight on warp 2; fflags read waits for both retires.
        issue_valid = 1'b1; issue_wid = 2'd2;
        tick(); tick();
        issue_valid = 1'b0;
        csr_req_valid = 1'b1; csr_req_wid = 2'd2; csr_req_addr = 12'h001;
        csr_req_op = 2'd0; csr_req_data = 32'h0;
        check("drain_acc_rdy", {31'b0, csr_req_ready}, 32'd1);
        tick();
        csr_req_valid = 1'b0;
        check("drain_wait_rdy", {31'b0, csr_req_ready}, 32'd0);
        check("drain_wait_rsp", {31'b0, csr_rsp_valid}, 32'd0);
        write_enable = 1'b1; write_wid = 2'd2; write_fflags = 5'h01;
        tick();
        write_enable = 1'b0; retire_valid = 1'b1; retire_wid = 2'd2;
        tick();
        retire_valid = 1'b0; write_enable = 1'b1; write_fflags = 5'h04;
        tick();
        write_enable = 1'b0;
        check("drain_mid_rsp", {31'b0, csr_rsp_valid}, 32'd0);
        retire_valid = 1'b1;
        tick();
        retire_valid = 1'b0;
        check("drain_early_rsp", {31'b0, csr_rsp_valid}, 32'd0);
        tick();
        check("drain_rsp_vld", {31'b0, csr_rsp_valid}, 32'd1);
        check("drain_rsp_data", csr_rsp_data, 32'h05);
        tick();

        // Saturation on warp 3 with PEND_W=2.
        issue_valid = 1'b1; issue_wid = 2'd3;
        for (int i = 0; i < 3; i++) begin
            check("sat_rdy", {31'b0, issue_ready}, 32'd1);
            tick();
        end
        check("sat_full", {31'b0, issue_ready}, 32'd0);
        issue_valid = 1'b0; retire_valid = 1'b1; retire_wid = 2'd3;
        tick();
        check("sat_after_ret", {31'b0, issue_ready}, 32'd1);
        issue_valid = 1'b1;
        tick();
        retire_valid = 1'b0;
        check("sat_inc_dec", {31'b0, issue_ready}, 32'd1);
        tick();
        issue_valid = 1'b0;
        check("sat_refull", {31'b0, issue_ready}, 32'd0);
        retire_valid = 1'b1;
        tick(); tick(); tick();
        retire_valid = 1'b0;

        // Reset during WAIT aborts the access.
        issue_valid = 1'b1; issue_wid = 2'd0;
        tick();
        issue_valid = 1'b0;
        csr_req_valid = 1'b1; csr_req_wid = 2'd0; csr_req_addr = 12'h003; csr_req_op = 2'd0;
        tick();
        csr_req_valid = 1'b0;
        check("wait_rdy_lo", {31'b0, csr_req_ready}, 32'd0);
        reset = 1'b0; #1;
        check("wrst_rsp", {31'b0, csr_rsp_valid}, 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("wrst_no_rsp", {31'b0, csr_rsp_valid}, 32'd0);
            tick();
        end
        check("wrst_req_rdy", {31'b0, csr_req_ready}, 32'd1);
        check("wrst_iss_rdy", {31'b0, issue_ready}, 32'd1);
        csr_acc(2'd0, 12'h003, 2'd0, 32'h0, 1'b0, 2'd0, 5'h0, rd, lat);
        check("wrst_lat", lat, 1);
        check("wrst_fcsr", rd, 32'h0);
`else
        // No drain: in-flight ops never delay an access and issue is always ready.
        issue_valid = 1'b1; issue_wid = 2'd2;
        for (int i = 0; i < 5; i++) begin
            check("nodrain_rdy", {31'b0, issue_ready}, 32'd1);
            tick();
        end
        issue_valid = 1'b0;
        write_enable = 1'b1; write_wid = 2'd2; write_fflags = 5'h05;
        tick();
        write_enable = 1'b0;
        csr_acc(2'd2, 12'h001, 2'd0, 32'h0, 1'b0, 2'd0, 5'h0, rd, lat);
        check("nodrain_lat", lat, 1);
        check("nodrain_rd", rd, 32'h05);

        // Reset during RESP drops the response at once.
        csr_req_valid = 1'b1; csr_req_wid = 2'd0; csr_req_addr = 12'h003; csr_req_op = 2'd0;
        tick();
        csr_req_valid = 1'b0;
        check("resp_pre_rst", {31'b0, csr_rsp_valid}, 32'd1);
        reset = 1'b0; #1;
        check("resp_rst_vld", {31'b0, csr_rsp_valid}, 32'd0);
        check("resp_rst_data", csr_rsp_data, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("rst_req_rdy2", {31'b0, csr_req_ready}, 32'd1);
        csr_acc(2'd0, 12'h003, 2'd0, 32'h0, 1'b0, 2'd0, 5'h0, rd, lat);
        check("rst_fcsr0", rd, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
